// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states and
// the default control/payload widths used by every stage.
package pipe_stage_reg_pkg;

  localparam int DEFAULT_CTRL_W = 10;
  localparam int DEFAULT_DATA_W = 144;

  // Encoding doubles as the stored-entry count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for a pipeline stage: upstream (in_*) and
// downstream (out_*) channels seen from the stage (slave) or its neighbours (master).
interface pipe_stage_reg_if #(
  parameter int CTRL_W = pipe_stage_reg_pkg::DEFAULT_CTRL_W,
  parameter int DATA_W = pipe_stage_reg_pkg::DEFAULT_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// One stored pipeline word: control field always clears on reset/clear,
// payload clears only when CLEAR_DATA is set, otherwise it simply holds.
module pipe_entry_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W     = DEFAULT_CTRL_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Control bits: clear wins over load so a flushed word never carries enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
    end
  end

  generate
    if (CLEAR_DATA != 0) begin : g_clearData
      // Payload zeroed alongside control on reset and clear
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_data <= '0;
        end else if (i_clear) begin
          r_data <= '0;
        end else if (i_load) begin
          r_data <= i_data;
        end
      end
    end else begin : g_holdData
      // Payload has no reset and keeps its value through a clear
      always_ff @(posedge clk) begin
        if (i_load && !i_clear) begin
          r_data <= i_data;
        end
      end
    end
  endgenerate

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and freeze.
// The main entry drives the outputs; the skid entry absorbs one word when
// downstream stalls, so in_ready never depends on out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W     = DEFAULT_CTRL_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CLEAR_DATA = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 freeze,
  pipe_stage_reg_if.slave      bus,
  output logic [1:0]           count
);

  stage_state_e      r_state;
  logic              w_inReady;
  logic              w_outValid;
  logic              w_push;
  logic              w_pop;
  logic              w_mainLoad;
  logic              w_skidLoad;
  logic [CTRL_W-1:0] w_mainCtrlIn;
  logic [DATA_W-1:0] w_mainDataIn;
  logic [CTRL_W-1:0] w_mainCtrl;
  logic [DATA_W-1:0] w_mainData;
  logic [CTRL_W-1:0] w_skidCtrl;
  logic [DATA_W-1:0] w_skidData;

  assign w_inReady  = reset_n && (r_state != ST_TWO) && !freeze && !flush;
  assign w_outValid = (r_state != ST_EMPTY) && !freeze;
  assign w_push     = bus.in_valid && w_inReady;
  assign w_pop      = w_outValid && bus.out_ready;

  // Main refills from the skid when draining TWO, otherwise from upstream
  assign w_mainLoad = !flush && (((r_state == ST_EMPTY) && w_push) ||
                                 ((r_state == ST_ONE) && w_push && w_pop) ||
                                 ((r_state == ST_TWO) && w_pop));
  assign w_skidLoad = !flush && (r_state == ST_ONE) && w_push && !w_pop;

  assign w_mainCtrlIn = (r_state == ST_TWO) ? w_skidCtrl : bus.in_ctrl;
  assign w_mainDataIn = (r_state == ST_TWO) ? w_skidData : bus.in_data;

  pipe_entry_reg #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_mainLoad),
    .i_clear (flush),
    .i_ctrl  (w_mainCtrlIn),
    .i_data  (w_mainDataIn),
    .o_ctrl  (w_mainCtrl),
    .o_data  (w_mainData)
  );

  pipe_entry_reg #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_skidLoad),
    .i_clear (flush),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_ctrl  (w_skidCtrl),
    .o_data  (w_skidData)
  );

  // Occupancy FSM; flush empties the stage regardless of handshakes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop) begin
            r_state <= ST_TWO;
          end else if (w_pop && !w_push) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO:   if (w_pop) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_ctrl  = w_outValid ? w_mainCtrl : '0;
  assign bus.out_data  = w_mainData;
  assign count         = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, freeze,
// payload retention with CLEAR_DATA=0 and asynchronous reset.
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 144;

  localparam logic [CW-1:0] CA = 10'h1A1;
  localparam logic [CW-1:0] CB = 10'h2B2;
  localparam logic [CW-1:0] CC = 10'h3C3;
  localparam logic [DW-1:0] DA = 144'hA0A0_1111;
  localparam logic [DW-1:0] DB = 144'hB0B0_2222;
  localparam logic [DW-1:0] DC = 144'hC0C0_3333;
  localparam logic [CW-1:0] CD = 10'h155;
  localparam logic [DW-1:0] DD = 144'hDEAD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0;
  logic       freeze = 1'b0;
  logic       flush2 = 1'b0;
  logic       freeze2 = 1'b0;
  logic [1:0] count;
  logic [1:0] count2;

  int nCompared = 0;
  int nMismatched = 0;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus2 ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) dut (
    .clk (clk), .reset_n (reset_n), .flush (flush), .freeze (freeze),
    .bus (bus), .count (count)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0)) dut2 (
    .clk (clk), .reset_n (reset_n), .flush (flush2), .freeze (freeze2),
    .bus (bus2), .count (count2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    nCompared++; if (bus.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
    nCompared++; if (bus.out_data !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
    nCompared++; if (count2 !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_count2: got %0d want 0", count2); end
    reset_n = 1'b1;
    #1;
    nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_streaming;
    bus.out_ready = 1'b1;
    drive_in(1'b1, CA, DA);
    tick();
    drive_in(1'b1, CB, DB);
    #1;
    nCompared++; if (bus.out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL stream_valid_A: got %b want 1", bus.out_valid); end
    nCompared++; if (bus.out_ctrl !== CA) begin nMismatched++; $display("[TB] FAIL stream_ctrl_A: got %h want %h", bus.out_ctrl, CA); end
    nCompared++; if (bus.out_data !== DA) begin nMismatched++; $display("[TB] FAIL stream_data_A: got %h want %h", bus.out_data, DA); end
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL stream_count_A: got %0d want 1", count); end
    tick();
    drive_in(1'b1, CC, DC);
    #1;
    nCompared++; if (bus.out_ctrl !== CB) begin nMismatched++; $display("[TB] FAIL stream_ctrl_B: got %h want %h", bus.out_ctrl, CB); end
    nCompared++; if (bus.out_data !== DB) begin nMismatched++; $display("[TB] FAIL stream_data_B: got %h want %h", bus.out_data, DB); end
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL stream_count_B: got %0d want 1", count); end
    tick();
    drive_in(1'b0, '0, '0);
    #1;
    nCompared++; if (bus.out_ctrl !== CC) begin nMismatched++; $display("[TB] FAIL stream_ctrl_C: got %h want %h", bus.out_ctrl, CC); end
    nCompared++; if (bus.out_data !== DC) begin nMismatched++; $display("[TB] FAIL stream_data_C: got %h want %h", bus.out_data, DC); end
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL stream_count_C: got %0d want 1", count); end
    tick();
    #1;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL stream_drain_count: got %0d want 0", count); end
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL stream_drain_valid: got %b want 0", bus.out_valid); end
    nCompared++; if (bus.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL stream_bubble_ctrl: got %h want 0", bus.out_ctrl); end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    drive_in(1'b1, CA, DA);
    tick();
    drive_in(1'b1, CB, DB);
    #1;
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL bp_count_one: got %0d want 1", count); end
    nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_ready_one: got %b want 1", bus.in_ready); end
    tick();
    drive_in(1'b0, '0, '0);
    #1;
    nCompared++; if (count !== 2'd2) begin nMismatched++; $display("[TB] FAIL bp_count_two: got %0d want 2", count); end
    nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_ready_two: got %b want 0", bus.in_ready); end
    nCompared++; if (bus.out_ctrl !== CA) begin nMismatched++; $display("[TB] FAIL bp_head_ctrl_A: got %h want %h", bus.out_ctrl, CA); end
    nCompared++; if (bus.out_data !== DA) begin nMismatched++; $display("[TB] FAIL bp_head_data_A: got %h want %h", bus.out_data, DA); end
    bus.out_ready = 1'b1;
    #1;
    nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_ready_no_comb_path: got %b want 0", bus.in_ready); end
    tick();
    #1;
    nCompared++; if (bus.out_ctrl !== CB) begin nMismatched++; $display("[TB] FAIL bp_head_ctrl_B: got %h want %h", bus.out_ctrl, CB); end
    nCompared++; if (bus.out_data !== DB) begin nMismatched++; $display("[TB] FAIL bp_head_data_B: got %h want %h", bus.out_data, DB); end
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL bp_count_after_pop: got %0d want 1", count); end
    nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
    tick();
    #1;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL bp_count_drained: got %0d want 0", count); end
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_valid_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    drive_in(1'b1, CA, DA);
    tick();
    drive_in(1'b1, CB, DB);
    tick();
    flush = 1'b1;
    drive_in(1'b1, CC, DC);
    bus.out_ready = 1'b1;
    #1;
    nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    drive_in(1'b0, '0, '0);
    #1;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    nCompared++; if (bus.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL flush_out_ctrl: got %h want 0", bus.out_ctrl); end
    nCompared++; if (bus.out_data !== '0) begin nMismatched++; $display("[TB] FAIL flush_out_data: got %h want 0", bus.out_data); end
    tick();
    tick();
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_word_dropped: got out_valid %b want 0", bus.out_valid); end
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL flush_stays_empty: got %0d want 0", count); end
  endtask

  task automatic test_freeze;
    bus.out_ready = 1'b0;
    drive_in(1'b1, CA, DA);
    tick();
    freeze = 1'b1;
    drive_in(1'b1, CB, DB);
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL freeze_out_valid_%0d: got %b want 0", i, bus.out_valid); end
      nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL freeze_in_ready_%0d: got %b want 0", i, bus.in_ready); end
      nCompared++; if (bus.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL freeze_out_ctrl_%0d: got %h want 0", i, bus.out_ctrl); end
      nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL freeze_count_%0d: got %0d want 1", i, count); end
      tick();
    end
    freeze = 1'b0;
    drive_in(1'b0, '0, '0);
    #1;
    nCompared++; if (bus.out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL unfreeze_valid: got %b want 1", bus.out_valid); end
    nCompared++; if (bus.out_ctrl !== CA) begin nMismatched++; $display("[TB] FAIL unfreeze_ctrl_A: got %h want %h", bus.out_ctrl, CA); end
    nCompared++; if (bus.out_data !== DA) begin nMismatched++; $display("[TB] FAIL unfreeze_data_A: got %h want %h", bus.out_data, DA); end
    tick();
    #1;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL unfreeze_drained: got %0d want 0", count); end
  endtask

  task automatic test_clear_data0;
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_ctrl   = CD;
    bus2.in_data   = DD;
    tick();
    bus2.in_valid = 1'b0;
    #1;
    nCompared++; if (bus2.out_ctrl !== CD) begin nMismatched++; $display("[TB] FAIL hold_loaded_ctrl: got %h want %h", bus2.out_ctrl, CD); end
    nCompared++; if (bus2.out_data !== DD) begin nMismatched++; $display("[TB] FAIL hold_loaded_data: got %h want %h", bus2.out_data, DD); end
    flush2 = 1'b1;
    tick();
    flush2 = 1'b0;
    #1;
    nCompared++; if (bus2.out_data !== DD) begin nMismatched++; $display("[TB] FAIL hold_flush_data: got %h want %h", bus2.out_data, DD); end
    nCompared++; if (bus2.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL hold_flush_ctrl: got %h want 0", bus2.out_ctrl); end
    nCompared++; if (bus2.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_flush_valid: got %b want 0", bus2.out_valid); end
    nCompared++; if (count2 !== 2'd0) begin nMismatched++; $display("[TB] FAIL hold_flush_count: got %0d want 0", count2); end
  endtask

  task automatic test_async_reset;
    bus.out_ready = 1'b0;
    drive_in(1'b1, CA, DA);
    tick();
    drive_in(1'b1, CB, DB);
    tick();
    drive_in(1'b0, '0, '0);
    #2;
    nCompared++; if (count !== 2'd2) begin nMismatched++; $display("[TB] FAIL areset_pre_count: got %0d want 2", count); end
    reset_n = 1'b0;
    #1;
    nCompared++; if (count !== 2'd0) begin nMismatched++; $display("[TB] FAIL areset_count: got %0d want 0", count); end
    nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL areset_out_valid: got %b want 0", bus.out_valid); end
    nCompared++; if (bus.out_ctrl !== '0) begin nMismatched++; $display("[TB] FAIL areset_out_ctrl: got %h want 0", bus.out_ctrl); end
    nCompared++; if (bus.out_data !== '0) begin nMismatched++; $display("[TB] FAIL areset_out_data: got %h want 0", bus.out_data); end
    nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL areset_in_ready: got %b want 0", bus.in_ready); end
    #2;
    reset_n = 1'b1;
    drive_in(1'b1, CC, DC);
    tick();
    drive_in(1'b0, '0, '0);
    #1;
    nCompared++; if (count !== 2'd1) begin nMismatched++; $display("[TB] FAIL areset_first_push_count: got %0d want 1", count); end
    nCompared++; if (bus.out_ctrl !== CC) begin nMismatched++; $display("[TB] FAIL areset_first_push_ctrl: got %h want %h", bus.out_ctrl, CC); end
    nCompared++; if (bus.out_data !== DC) begin nMismatched++; $display("[TB] FAIL areset_first_push_data: got %h want %h", bus.out_data, DC); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_ctrl    = '0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_ctrl   = '0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_clear_data0();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
